// File: rtl/fetch_buffer_if.sv
// Bus bundle for the instruction fetch stage: instruction-memory request/response,
// redirect from execute, and the valid/ready handshake towards decode.
// The master modport is the fetch buffer itself; slave is the surrounding pipeline.
interface fetch_buffer_if;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic [31:0] i_imem_rdata;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_instruction;
  logic [31:0] o_pc;
  logic [31:0] o_pc_plus4;

  modport master (
    output o_imem_req,
    output o_imem_addr,
    input  i_imem_rdata,
    input  i_redirect,
    input  i_redirect_pc,
    output o_valid,
    input  i_ready,
    output o_instruction,
    output o_pc,
    output o_pc_plus4
  );

  modport slave (
    input  o_imem_req,
    input  o_imem_addr,
    output i_imem_rdata,
    output i_redirect,
    output i_redirect_pc,
    input  o_valid,
    output i_ready,
    input  o_instruction,
    input  o_pc,
    input  o_pc_plus4
  );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction fetch stage. Keeps the fetch PC, issues one word request per cycle to a
// fixed 1-cycle-latency instruction memory, and parks returned words (with their PC) in a
// small circular FIFO that feeds decode through a valid/ready handshake.
// A credit check (buffered + in flight - leaving this cycle < DEPTH) guarantees every
// returning word has a free slot, so the FIFO never has to refuse a push.
// A redirect flushes the FIFO and the in-flight word and restarts fetch at the target.
module fetch_buffer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input logic            i_clk,
  input logic            i_rst,
  fetch_buffer_if.master bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [31:0]      NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0]      PC_ALIGN  = 32'hFFFF_FFFC;

  // Fetch PC and the PC of the word currently in flight
  logic [31:0]      r_pc;
  logic [31:0]      r_req_pc;
  logic             r_inflight;

  // FIFO bookkeeping and storage
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [31:0]      r_instr_mem [DEPTH];
  logic [31:0]      r_pc_mem    [DEPTH];

  // Combinational control
  logic             w_valid;
  logic             w_pop;
  logic             w_push;
  logic             w_req;
  logic [CNT_W:0]   w_credit;
  logic [PTR_W-1:0] w_head_next;
  logic [PTR_W-1:0] w_tail_next;
  logic [31:0]      w_redirect_pc;
  logic [31:0]      w_head_pc;
  logic [CNT_W-1:0] w_count_next;

  // Handshake, credit and request decisions for the current cycle
  always_comb begin
    w_valid       = ~i_rst & (r_count != '0);
    w_pop         = w_valid & bus.i_ready;
    w_push        = r_inflight & ~bus.i_redirect;
    w_credit      = {1'b0, r_count}
                  + {{CNT_W{1'b0}}, r_inflight}
                  - {{CNT_W{1'b0}}, w_pop};
    w_req         = ~i_rst & ~bus.i_redirect & (w_credit < {1'b0, DEPTH_CNT});
    w_redirect_pc = bus.i_redirect_pc & PC_ALIGN;
    w_head_pc     = r_pc_mem[r_head];
  end

  // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two)
  always_comb begin
    w_head_next = r_head + PTR_W'(1);
    w_tail_next = r_tail + PTR_W'(1);
    if (r_head == LAST_PTR) begin
      w_head_next = '0;
    end
    if (r_tail == LAST_PTR) begin
      w_tail_next = '0;
    end
  end

  // Occupancy after this cycle's push/pop; simultaneous push and pop leaves it unchanged
  always_comb begin
    w_count_next = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Outputs to memory and decode; decode sees a nop at PC 0 whenever the head is empty
  always_comb begin
    bus.o_imem_req    = w_req;
    bus.o_imem_addr   = r_pc;
    bus.o_valid       = w_valid;
    bus.o_instruction = NOP_INSTR;
    bus.o_pc          = '0;
    bus.o_pc_plus4    = '0;
    if (w_valid) begin
      bus.o_instruction = r_instr_mem[r_head];
      bus.o_pc          = w_head_pc;
      bus.o_pc_plus4    = w_head_pc + 32'd4;
    end
  end

  // Control state: reset beats redirect, redirect beats push/pop/request
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc       <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_inflight <= 1'b0;
      r_count    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
    end else if (bus.i_redirect) begin
      r_pc       <= w_redirect_pc;
      r_inflight <= 1'b0;
      r_count    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
    end else begin
      r_count <= w_count_next;
      if (w_push) begin
        r_tail <= w_tail_next;
      end
      if (w_pop) begin
        r_head <= w_head_next;
      end
      if (w_req) begin
        r_pc       <= r_pc + 32'd4;
        r_req_pc   <= r_pc;
        r_inflight <= 1'b1;
      end else begin
        r_inflight <= 1'b0;
      end
    end
  end

  // FIFO storage has no reset; entries are only read once the count says they are filled
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_push) begin
      r_instr_mem[r_tail] <= bus.i_imem_rdata;
      r_pc_mem[r_tail]    <= r_req_pc;
    end
  end

endmodule
